// File: rtl/mat_add_lite_n.sv
// mat_add_lite_n: AXI4-Lite slave holding operand banks A and B and a read-only
// result bank C. A start command runs an engine that adds one element per cycle
// in wrap or saturate mode, signed or unsigned, then raises a sticky done flag.
module mat_add_lite_n #(
  parameter int N      = 4,
  parameter int ELEM_W = 8,
  parameter int ADDR_W = 12
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic [2:0]        s_axi_awprot,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [2:0]        s_axi_arprot,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic              irq
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int TAG_W = ADDR_W - 8;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] K_CTRL   = 3'd0;
  localparam logic [2:0] K_STATUS = 3'd1;
  localparam logic [2:0] K_NSIZE  = 3'd2;
  localparam logic [2:0] K_A      = 3'd3;
  localparam logic [2:0] K_B      = 3'd4;
  localparam logic [2:0] K_C      = 3'd5;
  localparam logic [2:0] K_BAD    = 3'd6;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N - 1);
  localparam logic [ELEM_W-1:0] SMAX     = {ELEM_W{1'b1}} >> 1;
  localparam logic [ELEM_W-1:0] SMIN     = ~SMAX;

  logic [ELEM_W-1:0] a_mem [N];
  logic [ELEM_W-1:0] b_mem [N];
  logic [ELEM_W-1:0] c_mem [N];

  logic [0:0]       state;
  logic [IDX_W-1:0] idx;
  logic             busy, done, ovf;
  logic             ctrl_sat, ctrl_sgn, ctrl_irq_en;
  logic             run_sat, run_sgn;

  logic             wr_fire, rd_fire, wr_err, rd_err, start;
  logic [2:0]       wr_kind, rd_kind;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [31:0]      rd_word;

  logic [ELEM_W-1:0] op_a, op_b, wrap_res, elem_res;
  logic [ELEM_W:0]   sum;
  logic              ovf_u, ovf_s, elem_ovf;

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_wstrb,
                           s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata};

  // Classify a word address into a register or bank; out-of-range indices are unmapped.
  function automatic logic [2:0] decode(input logic [ADDR_W-3:0] waddr);
    logic [TAG_W-1:0] tag;
    logic [5:0]       word;
    logic             in_range;
    tag      = waddr[ADDR_W-3:6];
    word     = waddr[5:0];
    in_range = ({26'd0, word} < N);
    decode   = K_BAD;
    if (tag == TAG_W'(0)) begin
      if (word == 6'd0)      decode = K_CTRL;
      else if (word == 6'd1) decode = K_STATUS;
      else if (word == 6'd2) decode = K_NSIZE;
    end else if (tag == TAG_W'(1) && in_range) begin
      decode = K_A;
    end else if (tag == TAG_W'(2) && in_range) begin
      decode = K_B;
    end else if (tag == TAG_W'(3) && in_range) begin
      decode = K_C;
    end
  endfunction

  assign busy          = (state == ST_RUN);
  assign wr_fire       = s_axi_awvalid & s_axi_wvalid & ~s_axi_bvalid & ~ARESET;
  assign rd_fire       = s_axi_arvalid & ~s_axi_rvalid & ~ARESET;
  assign s_axi_awready = wr_fire;
  assign s_axi_wready  = wr_fire;
  assign s_axi_arready = rd_fire;
  assign wr_kind       = decode(s_axi_awaddr[ADDR_W-1:2]);
  assign rd_kind       = decode(s_axi_araddr[ADDR_W-1:2]);
  assign wr_idx        = s_axi_awaddr[2 +: IDX_W];
  assign rd_idx        = s_axi_araddr[2 +: IDX_W];
  assign start         = wr_fire && (wr_kind == K_CTRL) && s_axi_wdata[0] && !busy;
  assign irq           = done & ctrl_irq_en;

  // Decide the write response: read-only targets, unmapped space and bank writes while busy fail.
  always_comb begin
    wr_err = 1'b0;
    case (wr_kind)
      K_CTRL, K_STATUS: wr_err = 1'b0;
      K_A, K_B:         wr_err = busy;
      default:          wr_err = 1'b1;
    endcase
  end

  // Select read data; failing reads return zero.
  always_comb begin
    rd_word = 32'd0;
    rd_err  = 1'b0;
    case (rd_kind)
      K_CTRL:   rd_word = {28'd0, ctrl_irq_en, ctrl_sgn, ctrl_sat, 1'b0};
      K_STATUS: rd_word = {29'd0, ovf, done, busy};
      K_NSIZE:  rd_word = 32'(N);
      K_A:      rd_word = 32'(a_mem[rd_idx]);
      K_B:      rd_word = 32'(b_mem[rd_idx]);
      K_C:      rd_word = 32'(c_mem[rd_idx]);
      default:  rd_err  = 1'b1;
    endcase
  end

  // Add the current element pair and apply the overflow policy captured at start.
  always_comb begin
    op_a     = a_mem[idx];
    op_b     = b_mem[idx];
    sum      = {1'b0, op_a} + {1'b0, op_b};
    wrap_res = sum[ELEM_W-1:0];
    ovf_u    = sum[ELEM_W];
    ovf_s    = (op_a[ELEM_W-1] == op_b[ELEM_W-1]) && (wrap_res[ELEM_W-1] != op_a[ELEM_W-1]);
    elem_ovf = run_sgn ? ovf_s : ovf_u;
    elem_res = wrap_res;
    if (run_sat && elem_ovf) begin
      if (!run_sgn)            elem_res = {ELEM_W{1'b1}};
      else if (op_a[ELEM_W-1]) elem_res = SMIN;
      else                     elem_res = SMAX;
    end
  end

  // Write response channel: respond the cycle after acceptance and hold until taken.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= RESP_OKAY;
    end else if (wr_fire) begin
      s_axi_bvalid <= 1'b1;
      s_axi_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
    end else if (s_axi_bready) begin
      s_axi_bvalid <= 1'b0;
    end
  end

  // Read data channel: capture the addressed word on acceptance and hold until taken.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= 32'd0;
      s_axi_rresp  <= RESP_OKAY;
    end else if (rd_fire) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_word;
      s_axi_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
    end else if (s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

  // Operand banks are software-written, but only while the engine is idle.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < N; i++) begin
        a_mem[i] <= '0;
        b_mem[i] <= '0;
      end
    end else if (wr_fire && !busy) begin
      if (wr_kind == K_A) a_mem[wr_idx] <= s_axi_wdata[ELEM_W-1:0];
      if (wr_kind == K_B) b_mem[wr_idx] <= s_axi_wdata[ELEM_W-1:0];
    end
  end

  // Result bank is filled by the engine, one element per running cycle.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < N; i++) c_mem[i] <= '0;
    end else if (state == ST_RUN) begin
      c_mem[idx] <= elem_res;
    end
  end

  // Control fields, sticky status and the engine sequencer; engine sets beat W1C clears.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= ST_IDLE;
      idx         <= '0;
      done        <= 1'b0;
      ovf         <= 1'b0;
      ctrl_sat    <= 1'b0;
      ctrl_sgn    <= 1'b0;
      ctrl_irq_en <= 1'b0;
      run_sat     <= 1'b0;
      run_sgn     <= 1'b0;
    end else begin
      if (wr_fire && wr_kind == K_CTRL) begin
        ctrl_sat    <= s_axi_wdata[1];
        ctrl_sgn    <= s_axi_wdata[2];
        ctrl_irq_en <= s_axi_wdata[3];
      end
      if (wr_fire && wr_kind == K_STATUS) begin
        if (s_axi_wdata[1]) done <= 1'b0;
        if (s_axi_wdata[2]) ovf  <= 1'b0;
      end
      if (start) begin
        state   <= ST_RUN;
        idx     <= '0;
        done    <= 1'b0;
        ovf     <= 1'b0;
        run_sat <= s_axi_wdata[1];
        run_sgn <= s_axi_wdata[2];
      end else if (state == ST_RUN) begin
        if (elem_ovf) ovf <= 1'b1;
        if (idx == LAST_IDX) begin
          done  <= 1'b1;
          state <= ST_IDLE;
          idx   <= '0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mat_add_lite_n.sv
// tb_mat_add_lite_n: drives mat_add_lite_n over AXI4-Lite and compares results
// against an integer-arithmetic reference of the element-add rules.
module tb_mat_add_lite_n;

  localparam int N      = 4;
  localparam int ELEM_W = 8;
  localparam int ADDR_W = 12;
  localparam int TMO    = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [2:0]        awprot, arprot;
  logic              awvalid, awready, wvalid, wready;
  logic [31:0]       wdata, rdata;
  logic [3:0]        wstrb;
  logic [1:0]        bresp, rresp;
  logic              bvalid, bready, arvalid, arready, rvalid, rready;
  logic              irq;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   wr_hs_cyc = -1;
  int   irq_rise_cyc = -1;
  logic irq_q = 1'b0;
  int   ref_a [N];
  int   ref_b [N];

  mat_add_lite_n #(.N(N), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W)) dut (
    .ACLK(clk), .ARESET(rst),
    .s_axi_awaddr(awaddr), .s_axi_awprot(awprot), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(arprot), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .irq(irq)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Remember the cycle of the most recent accepted write.
  always @(posedge clk) if (awvalid && awready && wvalid && wready) wr_hs_cyc <= cyc;

  // Remember the cycle in which irq last rose.
  always @(negedge clk) begin
    if (irq && !irq_q) irq_rise_cyc = cyc;
    irq_q = irq;
  end

  // Reference element add using plain integer arithmetic and range limits.
  function automatic void ref_add(input int a, input int b, input bit sat, input bit sgn,
                                  output int c, output bit ov);
    int s, hi, lo, sa, sb;
    if (!sgn) begin
      s  = a + b;
      hi = (1 << ELEM_W) - 1;
      lo = 0;
    end else begin
      sa = (a >= (1 << (ELEM_W - 1))) ? a - (1 << ELEM_W) : a;
      sb = (b >= (1 << (ELEM_W - 1))) ? b - (1 << ELEM_W) : b;
      s  = sa + sb;
      hi = (1 << (ELEM_W - 1)) - 1;
      lo = -(1 << (ELEM_W - 1));
    end
    ov = (s > hi) || (s < lo);
    if (sat && s > hi) s = hi;
    if (sat && s < lo) s = lo;
    c = s & ((1 << ELEM_W) - 1);
  endfunction

  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data, output logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!(awready && wready) && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) begin
      total++; bad++;
      $display("[TB] FAIL aw_accept addr=%0h: not accepted, required within %0d cycles", addr, TMO);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!bvalid && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) begin
      total++; bad++;
      $display("[TB] FAIL b_valid addr=%0h: no response, required within %0d cycles", addr, TMO);
    end
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output int hs_cyc);
    int n;
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < TMO) begin @(negedge clk); n++; end
    hs_cyc = cyc;
    if (n >= TMO) begin
      total++; bad++;
      $display("[TB] FAIL ar_accept addr=%0h: not accepted, required within %0d cycles", addr, TMO);
    end
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) begin
      total++; bad++;
      $display("[TB] FAIL r_valid addr=%0h: no data, required within %0d cycles", addr, TMO);
    end
    data = rdata; resp = rresp;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic load_operands(input int a [N], input int b [N]);
    logic [1:0] rs;
    for (int i = 0; i < N; i++) begin
      axi_write(12'h100 + 12'(4 * i), 32'(a[i]), rs);
      axi_write(12'h200 + 12'(4 * i), 32'(b[i]), rs);
      ref_a[i] = a[i];
      ref_b[i] = b[i];
    end
  endtask

  task automatic wait_done(output logic [31:0] status);
    logic [1:0] rs;
    int hc, n;
    n = 0;
    status = 32'd0;
    while (!status[1] && n < 20) begin
      axi_read(12'h004, status, rs, hc);
      n++;
    end
    if (!status[1]) begin
      total++; bad++;
      $display("[TB] FAIL done_wait: status=%0h, required done within 20 polls", status);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    logic [1:0]  rs;
    int hc;
    total++; if ({bvalid, rvalid, irq} !== 3'b000) begin bad++; $display("[TB] FAIL reset_outputs: bvalid/rvalid/irq=%b required 000", {bvalid, rvalid, irq}); end
    axi_read(12'h004, d, rs, hc);
    total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL reset_status: got %0h required 0", d); end
    axi_read(12'h008, d, rs, hc);
    total++; if (d !== 32'(N) || rs !== 2'b00) begin bad++; $display("[TB] FAIL nsize: got %0h/%b required %0h/00", d, rs, N); end
    axi_read(12'h000, d, rs, hc);
    total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL reset_ctrl: got %0h required 0", d); end
    for (int i = 0; i < N; i++) begin
      axi_read(12'h300 + 12'(4 * i), d, rs, hc);
      total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL reset_c%0d: got %0h required 0", i, d); end
    end
  endtask

  task automatic test_unsigned_wrap;
    logic [31:0] d, st, rd [3];
    logic [1:0]  rs, rsw;
    int hc [3];
    int exp_c [N] = '{2, 5, 4, 0};
    int k;
    load_operands('{1, 2, 250, 255}, '{1, 3, 10, 1});
    fork
      axi_write(12'h000, 32'h1, rsw);
      begin
        for (int r = 0; r < 3; r++) begin
          if (r == 1) @(posedge clk);
          axi_read(12'h004, rd[r], rs, hc[r]);
        end
      end
    join
    for (int r = 0; r < 3; r++) begin
      k = hc[r] - wr_hs_cyc;
      total++;
      if (rd[r][0] !== ((k >= 1 && k <= N) ? 1'b1 : 1'b0)) begin
        bad++; $display("[TB] FAIL busy_at_%0d: got %b required %b", k, rd[r][0], (k >= 1 && k <= N));
      end
      if (k >= 1) begin
        total++;
        if (rd[r][1] !== ((k >= N + 1) ? 1'b1 : 1'b0)) begin
          bad++; $display("[TB] FAIL done_at_%0d: got %b required %b", k, rd[r][1], (k >= N + 1));
        end
      end
    end
    wait_done(st);
    total++; if (st !== 32'h6) begin bad++; $display("[TB] FAIL wrap_status: got %0h required 6", st); end
    for (int i = 0; i < N; i++) begin
      axi_read(12'h300 + 12'(4 * i), d, rs, hc[0]);
      total++; if (d !== 32'(exp_c[i])) begin bad++; $display("[TB] FAIL wrap_c%0d: got %0h required %0h", i, d, exp_c[i]); end
    end
  endtask

  task automatic test_unsigned_sat;
    logic [31:0] d, st;
    logic [1:0]  rs;
    int hc;
    int exp_c [N] = '{2, 5, 255, 255};
    axi_write(12'h000, 32'h3, rs);
    wait_done(st);
    total++; if (st !== 32'h6) begin bad++; $display("[TB] FAIL usat_status: got %0h required 6", st); end
    for (int i = 0; i < N; i++) begin
      axi_read(12'h300 + 12'(4 * i), d, rs, hc);
      total++; if (d !== 32'(exp_c[i])) begin bad++; $display("[TB] FAIL usat_c%0d: got %0h required %0h", i, d, exp_c[i]); end
    end
  endtask

  task automatic test_signed_sat;
    logic [31:0] d, st;
    logic [1:0]  rs;
    int hc;
    int exp_c [N] = '{8'h7F, 8'h80, 8'h00, 8'hFE};
    load_operands('{8'h7F, 8'h80, 8'h05, 8'hFF}, '{8'h01, 8'hFF, 8'hFB, 8'hFF});
    axi_write(12'h000, 32'h7, rs);
    wait_done(st);
    total++; if (st !== 32'h6) begin bad++; $display("[TB] FAIL ssat_status: got %0h required 6", st); end
    for (int i = 0; i < N; i++) begin
      axi_read(12'h300 + 12'(4 * i), d, rs, hc);
      total++; if (d !== 32'(exp_c[i])) begin bad++; $display("[TB] FAIL ssat_c%0d: got %0h required %0h", i, d, exp_c[i]); end
    end
  endtask

  task automatic test_errors;
    logic [31:0] d, st;
    logic [1:0]  rs;
    int hc;
    load_operands('{8'h10, 8'h20, 8'h30, 8'h40}, '{8'h01, 8'h02, 8'h03, 8'hC0});
    axi_write(12'h000, 32'h1, rs);
    axi_write(12'h100, 32'h55, rs);
    total++; if (rs !== 2'b10) begin bad++; $display("[TB] FAIL busy_a_write_resp: got %b required 10", rs); end
    wait_done(st);
    axi_read(12'h100, d, rs, hc);
    total++; if (d !== 32'h10) begin bad++; $display("[TB] FAIL a0_kept: got %0h required 10", d); end
    axi_write(12'h304, 32'hAB, rs);
    total++; if (rs !== 2'b10) begin bad++; $display("[TB] FAIL c_write_resp: got %b required 10", rs); end
    axi_read(12'h304, d, rs, hc);
    total++; if (d !== 32'h22) begin bad++; $display("[TB] FAIL c1_kept: got %0h required 22", d); end
    axi_read(12'h304 + 12'(4 * N), d, rs, hc);
    total++; if (rs !== 2'b10 || d !== 32'h0) begin bad++; $display("[TB] FAIL c_oob_read: got %0h/%b required 0/10", d, rs); end
    axi_write(12'h008, 32'h9, rs);
    total++; if (rs !== 2'b10) begin bad++; $display("[TB] FAIL nsize_write_resp: got %b required 10", rs); end
    axi_read(12'h00C, d, rs, hc);
    total++; if (rs !== 2'b10 || d !== 32'h0) begin bad++; $display("[TB] FAIL unmapped_read: got %0h/%b required 0/10", d, rs); end
    axi_write(12'h000, 32'h1, rs);
    axi_write(12'h000, 32'hB, rs);
    total++; if (rs !== 2'b00) begin bad++; $display("[TB] FAIL busy_start_resp: got %b required 00", rs); end
    wait_done(st);
    axi_read(12'h000, d, rs, hc);
    total++; if (d !== 32'hA) begin bad++; $display("[TB] FAIL ctrl_latched: got %0h required a", d); end
    axi_read(12'h30C, d, rs, hc);
    total++; if (d !== 32'h00) begin bad++; $display("[TB] FAIL mode_snapshot_c3: got %0h required 0", d); end
    total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_latched_en: got %b required 1", irq); end
    axi_write(12'h000, 32'h0, rs);
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_disable: got %b required 0", irq); end
  endtask

  task automatic test_irq_handshake;
    logic [31:0] d, st, d0;
    logic [1:0]  rs;
    int hc, n;
    irq_rise_cyc = -1;
    axi_write(12'h000, 32'h9, rs);
    wait_done(st);
    total++; if (irq_rise_cyc - wr_hs_cyc !== N + 1) begin bad++; $display("[TB] FAIL irq_latency: got %0d required %0d", irq_rise_cyc - wr_hs_cyc, N + 1); end
    total++; if (irq !== 1'b1 || st !== 32'h6) begin bad++; $display("[TB] FAIL irq_done: irq=%b status=%0h required 1/6", irq, st); end
    axi_write(12'h004, 32'h2, rs);
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_w1c: got %b required 0", irq); end
    axi_read(12'h004, d, rs, hc);
    total++; if (d !== 32'h4) begin bad++; $display("[TB] FAIL w1c_status: got %0h required 4", d); end
    @(posedge clk); #1;
    awaddr = 12'h104; wdata = 32'h5A; awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!awready && n < TMO) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin bad++; $display("[TB] FAIL b_stall_%0d: bvalid/bresp=%b/%b required 1/00", c, bvalid, bresp); end
    end
    @(posedge clk); #1; bready = 1'b1;
    @(posedge clk); #1; bready = 1'b0;
    @(negedge clk);
    total++; if (bvalid !== 1'b0) begin bad++; $display("[TB] FAIL b_release: got %b required 0", bvalid); end
    ref_a[1] = 8'h5A;
    @(posedge clk); #1;
    araddr = 12'h104; arvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!arready && n < TMO) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    d0 = rdata;
    for (int c = 0; c < 5; c++) begin
      total++; if (rvalid !== 1'b1 || rdata !== 32'h5A) begin bad++; $display("[TB] FAIL r_stall_%0d: rvalid/rdata=%b/%0h required 1/5a", c, rvalid, rdata); end
      @(negedge clk);
    end
    total++; if (rdata !== d0) begin bad++; $display("[TB] FAIL r_stable: got %0h required %0h", rdata, d0); end
    @(posedge clk); #1; rready = 1'b1;
    @(posedge clk); #1; rready = 1'b0;
    @(negedge clk);
    total++; if (rvalid !== 1'b0) begin bad++; $display("[TB] FAIL r_release: got %b required 0", rvalid); end
  endtask

  task automatic test_random;
    logic [31:0] d, st;
    logic [1:0]  rs;
    int hc, c_exp;
    int a [N];
    int b [N];
    bit sat, sgn, ov, ov_any;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N; i++) begin
        a[i] = int'($urandom_range(0, (1 << ELEM_W) - 1));
        b[i] = int'($urandom_range(0, (1 << ELEM_W) - 1));
      end
      sat = 1'($urandom_range(0, 1));
      sgn = 1'($urandom_range(0, 1));
      load_operands(a, b);
      axi_write(12'h000, {29'd0, sgn, sat, 1'b1}, rs);
      wait_done(st);
      ov_any = 1'b0;
      for (int i = 0; i < N; i++) begin
        ref_add(ref_a[i], ref_b[i], sat, sgn, c_exp, ov);
        ov_any |= ov;
        axi_read(12'h300 + 12'(4 * i), d, rs, hc);
        total++; if (d !== 32'(c_exp)) begin bad++; $display("[TB] FAIL rand%0d_c%0d: a=%0h b=%0h sat=%b sgn=%b got %0h required %0h", r, i, ref_a[i], ref_b[i], sat, sgn, d, c_exp); end
      end
      total++; if (st[2] !== ov_any) begin bad++; $display("[TB] FAIL rand%0d_ovf: got %b required %b", r, st[2], ov_any); end
    end
  endtask

  task automatic test_reset_midrun;
    logic [31:0] d;
    logic [1:0]  rs;
    int hc;
    axi_write(12'h000, 32'h9, rs);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    axi_read(12'h004, d, rs, hc);
    total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL midrun_status: got %0h required 0", d); end
    axi_read(12'h100, d, rs, hc);
    total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL midrun_a0: got %0h required 0", d); end
    axi_read(12'h300, d, rs, hc);
    total++; if (d !== 32'h0) begin bad++; $display("[TB] FAIL midrun_c0: got %0h required 0", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL midrun_irq: got %b required 0", irq); end
  endtask

  // Apply reset, then run each scenario in order and report the totals.
  initial begin
    rst = 1'b1;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wstrb = 4'hF; wdata = '0;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_unsigned_wrap();
    test_unsigned_sat();
    test_signed_sat();
    test_errors();
    test_irq_handshake();
    test_random();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
